// File: rtl/round_robin_arb_n.sv
// -----------------------------------------------------------------------------
// round_robin_arb_n
//
// N-requester round-robin arbiter with a time-slice limit, used on the
// crossbar master-to-slave path. The grant is one-hot and registered. The
// owner keeps it while it requests. It is preempted after SLICE_LEN
// consecutive cycles only if another requester is waiting. Priority rotates
// from the last owner, so no requester starves.
//
// Parameters:
//   NUM_REQ    number of requesters (2..32)
//   SLICE_LEN  maximum consecutive grant cycles under contention (>= 1)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   req        request vector, bit i = requester i
//   lock       per-requester slice lock (only when RR_ARB_LOCK_EN is defined)
//   grnt       registered one-hot grant, all-zero when idle
//   grnt_vld   registered, equals |grnt
//   grnt_id    registered index of the current owner, 0 when idle
//   slice_exp  registered one-cycle pulse when the owner is preempted by
//              slice expiry
//
// Optional feature macro: RR_ARB_LOCK_EN
//   When this macro is defined, the lock input exists. While the owner holds
//   lock[g] and req[g], slice expiry is suppressed and the timer parks at
//   SLICE_LEN-1. Preemption then happens on the first edge after lock falls.
// -----------------------------------------------------------------------------
module round_robin_arb_n #(
    parameter int NUM_REQ   = 4,
    parameter int SLICE_LEN = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
`ifdef RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           lock,
`endif
    output logic [NUM_REQ-1:0]           grnt,
    output logic                         grnt_vld,
    output logic [$clog2(NUM_REQ)-1:0]   grnt_id,
    output logic                         slice_exp
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(SLICE_LEN) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SLICE_LEN - 1);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state,   nxt_state;
    logic [ID_W-1:0]    ptr,     nxt_ptr;      // last (or current) owner
    logic [TMR_W-1:0]   timer,   nxt_timer;    // cycles held minus one
    logic [NUM_REQ-1:0] nxt_grnt;
    logic [ID_W-1:0]    nxt_id;
    logic               nxt_slice_exp;

    logic [NUM_REQ-1:0] others;       // requesters other than the owner
    logic [ID_W-1:0]    cand_req;     // next(ptr, req)
    logic [ID_W-1:0]    cand_oth;     // next(ptr, others)
    logic               locked;

    // First set bit of mask scanning cyclically p+1, p+2, ..., p+NUM_REQ.
    // The last position examined is p itself, so a lone request from the
    // previous owner is still found.
    function automatic logic [ID_W-1:0] rr_next(
        input logic [ID_W-1:0]    p,
        input logic [NUM_REQ-1:0] mask
    );
        logic [ID_W-1:0] sel;
        logic [ID_W-1:0] idx_w;
        logic            found;
        int              idx;
        sel   = p;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!found && mask[idx_w]) begin
                sel   = idx_w;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // In GRANT, ptr always equals the owner index, so it serves as the owner
    // in both scans. In IDLE, it is the last owner, which sets the rotation start.
    assign others   = req & ~onehot(ptr);
    assign cand_req = rr_next(ptr, req);
    assign cand_oth = rr_next(ptr, others);

`ifdef RR_ARB_LOCK_EN
    assign locked = lock[ptr] & req[ptr];
`else
    assign locked = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        nxt_state     = state;
        nxt_ptr       = ptr;
        nxt_timer     = timer;
        nxt_grnt      = grnt;
        nxt_id        = grnt_id;
        nxt_slice_exp = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    nxt_state = GRANT;
                    nxt_ptr   = cand_req;
                    nxt_grnt  = onehot(cand_req);
                    nxt_id    = cand_req;
                    nxt_timer = '0;
                end else begin
                    nxt_grnt = '0;
                    nxt_id   = '0;
                end
            end

            GRANT: begin
                if (!req[ptr]) begin
                    // Release. Here, req equals others, so cand_oth is
                    // next(g, req). Hand over directly with no idle cycle.
                    if (|req) begin
                        nxt_ptr   = cand_oth;
                        nxt_grnt  = onehot(cand_oth);
                        nxt_id    = cand_oth;
                        nxt_timer = '0;
                    end else begin
                        nxt_state = IDLE;
                        nxt_grnt  = '0;
                        nxt_id    = '0;
                        nxt_timer = '0;
                    end
                end else if (timer == TMR_LAST) begin
                    if ((|others) && !locked) begin
                        // Slice expiry with someone waiting, so preempt.
                        nxt_ptr       = cand_oth;
                        nxt_grnt      = onehot(cand_oth);
                        nxt_id        = cand_oth;
                        nxt_timer     = '0;
                        nxt_slice_exp = 1'b1;
                    end else if (locked) begin
                        // Park at the last slice cycle. Preemption fires on
                        // the first edge after the lock falls.
                        nxt_timer = timer;
                    end else begin
                        // No contention, so start a fresh slice.
                        nxt_timer = '0;
                    end
                end else begin
                    nxt_timer = timer + TMR_W'(1);
                end
            end

            default: begin
                nxt_state = IDLE;
                nxt_grnt  = '0;
                nxt_id    = '0;
                nxt_timer = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            timer     <= '0;
            grnt      <= '0;
            grnt_vld  <= 1'b0;
            grnt_id   <= '0;
            slice_exp <= 1'b0;
        end else begin
            state     <= nxt_state;
            ptr       <= nxt_ptr;
            timer     <= nxt_timer;
            grnt      <= nxt_grnt;
            grnt_vld  <= |nxt_grnt;
            grnt_id   <= nxt_id;
            slice_exp <= nxt_slice_exp;
        end
    end

    // The grant must be one-hot or zero, and it must agree with grnt_id/grnt_vld.
    a_grnt_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(grnt));

    a_grnt_consistent : assert property (@(posedge clk) disable iff (reset)
        (grnt_vld == (|grnt)) && (!grnt_vld || (grnt == onehot(grnt_id))));

endmodule

// File: tb/tb_round_robin_arb_n.sv
// -----------------------------------------------------------------------------
// tb_round_robin_arb_n
//
// Directed bench for round_robin_arb_n with NUM_REQ=4 and SLICE_LEN=16.
// Each step drives reset/req, queues the grant expected after the next
// rising edge, then pops and compares that expectation 1 ns after the edge.
// The lock scenario is compiled only when RR_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_round_robin_arb_n;

    localparam int NUM_REQ   = 4;
    localparam int SLICE_LEN = 16;

    logic                       clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         lock;
    logic [NUM_REQ-1:0]         grnt;
    logic                       grnt_vld;
    logic [$clog2(NUM_REQ)-1:0] grnt_id;
    logic                       slice_exp;

    int total;
    int bad;

    typedef struct {
        string      tag;
        logic [3:0] grnt;
        logic [1:0] id;
        logic       sexp;
    } exp_t;

    exp_t exp_q[$];

    round_robin_arb_n #(
        .NUM_REQ   (NUM_REQ),
        .SLICE_LEN (SLICE_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grnt      (grnt),
        .grnt_vld  (grnt_vld),
        .grnt_id   (grnt_id),
        .slice_exp (slice_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus. Queue what the DUT must show after the
    // edge. Then sample away from the edge and compare against the queue.
    task automatic step(input logic rst, input logic [3:0] r,
                        input logic [3:0] eg, input logic [1:0] eid,
                        input logic es, input string tag);
        exp_t e;
        reset = rst;
        req   = r;
        exp_q.push_back('{tag: tag, grnt: eg, id: eid, sexp: es});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".grnt"},      32'(grnt),      32'(e.grnt));
        check({e.tag, ".grnt_vld"},  32'(grnt_vld),  32'(|e.grnt));
        check({e.tag, ".grnt_id"},   32'(grnt_id),   32'(e.id));
        check({e.tag, ".slice_exp"}, 32'(slice_exp), 32'(e.sexp));
    endtask

    initial begin
        logic [1:0] own;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state, then idle with no requests.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, $sformatf("idle%0d", i));
        end

        // A single requester is granted one cycle later and is held with no expiry.
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_grant");
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, $sformatf("single_hold%0d", i));
        end

        // Reset applied mid-grant clears the grant on the next cycle.
        step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, "mid_reset");

        // Full contention: owners 0,1,2,3,0, each holding exactly SLICE_LEN cycles.
        for (int k = 0; k < 5; k++) begin
            own = 2'(k % 4);
            for (int c = 0; c < SLICE_LEN; c++) begin
                step(1'b0, 4'b1111, 4'(1 << own), own, (c == 0) && (k > 0),
                     $sformatf("rot%0d_%0d", k, c));
            end
        end

        // All requests drop, so the grant goes to zero next cycle (last owner 0).
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rot_release");

        // Owner 1 drops after 3 cycles while 3 waits, giving a direct handover.
        step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0, "rel_grant1");
        step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0, "rel_hold1a");
        step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0, "rel_hold1b");
        step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "rel_to3");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rel_idle");

        // Leave the last owner at 2. From IDLE, 0011 scans 3,0,1 and grants 0.
        step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "ptr2_grant");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "ptr2_idle");
        for (int c = 0; c < SLICE_LEN; c++) begin
            step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, $sformatf("ptr2_own0_%0d", c));
        end
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "ptr2_exp_to1");
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0, "ptr2_hold1");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "ptr2_release");

`ifdef RR_ARB_LOCK_EN
        // Last owner is 1. 0011 scans 2,3,0 and grants 0. lock[0] holds it
        // well past the slice. Dropping lock preempts on the next edge.
        lock = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, $sformatf("lock_hold%0d", c));
        end
        lock = 4'b0000;
        step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, "lock_drop");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "lock_release");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_robin_arb_n.md
Name: round_robin_arb_n

Overview:
- Parametrised N-requester round-robin arbiter with a time-slice limit.
- Serves the crossbar master-to-slave path and replaces the fixed 2-requester arbiter for slave ports with more than two masters.
- Grant is one-hot and registered. It is held while the owner requests, and is preempted after SLICE_LEN cycles only if another requester is waiting.
- Priority rotates from the last owner, so no requester starves.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..32.
- SLICE_LEN, 16, maximum consecutive grant cycles under contention; must be >= 1.
- ID_W, $clog2(NUM_REQ), width of grnt_id (derived localparam, not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  request vector, bit i = requester i
- grnt  output  NUM_REQ  registered one-hot grant, all-zero when idle
- grnt_vld  output  1  registered, equals |grnt
- grnt_id  output  ID_W  registered index of the current owner; 0 when idle
- slice_exp  output  1  registered one-cycle pulse on preemption by slice expiry
- lock  input  NUM_REQ  present only with RR_ARB_LOCK_EN (see below)

Behaviour:
- Reset (reset=1 at an edge) clears grnt, grnt_vld, grnt_id, slice_exp and timer to 0.
  - Reset also sets ptr = NUM_REQ-1, so requester 0 has top priority first.
  - Reset overrides everything, including mid-grant. Outputs read 0 on the cycle after the reset edge.
- State machine: IDLE, GRANT. Internal registers: ptr (last owner index), timer (width $clog2(SLICE_LEN)+1).
- Selection function next(p, mask): the first set bit of mask when scanning cyclically p+1, p+2, …, p+NUM_REQ (mod NUM_REQ).
- IDLE:
  - If req==0: stay in IDLE, grnt=0.
  - Otherwise: g = next(ptr, req). Next cycle grnt=onehot(g), grnt_id=g, ptr=g, timer=0, state goes to GRANT.
  - Latency from request to grant is 1 cycle.
- GRANT, owner g, evaluated each edge in this priority order:
  1. req[g]==0, release. If req has other bits set: switch directly to g' = next(g, req), timer=0, with no idle cycle. Else go to IDLE with grnt=0 on the next cycle.
  2. timer==SLICE_LEN-1 and (req & ~onehot(g)) != 0, expiry. Switch to g' = next(g, req & ~onehot(g)), set timer=0, and set slice_exp=1 for one cycle.
  3. timer==SLICE_LEN-1 with no other requester: hold grant and wrap timer to 0. No slice_exp.
  4. Otherwise hold grant, timer+1.
- Under permanent full contention, each owner holds exactly SLICE_LEN cycles, and grants go in order 0,1,…,NUM_REQ-1,0,…
- SLICE_LEN=1 under contention gives a single-cycle rotation.
- Every switch updates ptr to the new owner.
- A requester rising while another owns the grant waits; it is never granted in the same cycle it is first seen.
- grnt is always one-hot or zero. Any other value is a design error (assert in simulation).
- Target size of the RTL: about 150-250 lines. Use for-loop priority scans with no hardcoded widths.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- With the macro:
  - The lock[NUM_REQ] input port exists.
  - While the owner g has lock[g]=1 and req[g]=1, the expiry rule (2) is suppressed and the timer holds at SLICE_LEN-1.
  - When lock[g] falls with contention present, preemption occurs at the next edge.
  - Release by req[g]=0 works regardless of lock.
- Without the macro: no lock port, and rule (2) always applies.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grnt=0, grnt_vld=0, grnt_id=0, slice_exp=0. Assert reset for 1 cycle mid-grant -> grnt=0 on the next cycle.
- After reset, req=4'b0100 -> grnt=4'b0100, grnt_id=2 one cycle later. Held while req stays set, with no slice_exp even after 40 cycles (single requester).
- req=4'b1111 constant, SLICE_LEN=16 -> grant sequence 0001,0010,0100,1000,0001, each held exactly 16 cycles. slice_exp pulses on each switch edge.
- Owner 1 drops req after 3 cycles while req[3]=1 -> grnt=4'b1000 on the next cycle, with no idle gap and no slice_exp. Then all req drop -> grnt=0 next cycle.
- ptr=2 (last owner 2), from IDLE req=4'b0011 -> grant goes to 0 (scan 3,0,1), then after expiry to 1.
- With RR_ARB_LOCK_EN: req=4'b0011, lock[0]=1 held 40 cycles -> requester 0 keeps the grant for all 40 cycles. lock[0] drops -> grnt=4'b0010 on the next edge with slice_exp=1.
